melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, reference clock frequency in Hz.
REQ-002 SHALL have parameter DUR_MS, default 200, length of each note in ms (1..255).
REQ-003 SHALL have parameter GAP_MS, default 20, silent gap after each note in ms (0..255).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request to play the melody; sampled each cycle.
REQ-007 SHALL have port stop  input  1  request to abort playback; sampled each cycle.
REQ-008 SHALL have port bz1  output  1  square-wave buzzer drive, registered.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the last note's gap completes.
REQ-011 SHALL have port note_idx  output  3  index of the note being played or gapped, 0..7.

Function
REQ-012 SHALL hold an 8-entry constant note table with frequencies 523, 587, 659, 698, 784, 880, 988, 1047 Hz for indices 0..7.
REQ-013 SHALL compute each half-period as floor(CLK_HZ/(2*freq)) at elaboration; the counters SHALL be 27 bits wide.
REQ-014 SHALL derive a 1 ms tick from a prescaler that pulses once every floor(CLK_HZ/1000) cycles, counting only while in PLAY or GAP and cleared on entry to each state.
REQ-015 SHALL implement states IDLE, LOAD, PLAY and GAP.
REQ-016 In IDLE, start=1 and stop=0 SHALL transition to LOAD with note_idx=0; start is ignored in any other state.
REQ-017 LOAD SHALL last exactly one cycle, latch the half-period for note_idx, clear the tone and ms counters and go to PLAY.
REQ-018 In PLAY, the tone counter SHALL increment each cycle, and on reaching half-period-1 it SHALL toggle bz1 and reset to 0; the first toggle SHALL occur half-period cycles after PLAY entry.
REQ-019 PLAY SHALL go to GAP after DUR_MS ticks; on leaving PLAY, bz1 SHALL be forced to 0.
REQ-020 GAP SHALL hold bz1=0 for GAP_MS ticks; with GAP_MS=0 it SHALL last one cycle.
REQ-021 At the end of GAP, if note_idx<7, the block SHALL increment note_idx and go to LOAD; if note_idx=7, it SHALL pulse done for one cycle, go to IDLE and reset note_idx to 0.
REQ-022 stop=1 in LOAD, PLAY or GAP SHALL go to IDLE on the next edge with bz1=0, note_idx=0, and no done pulse.
REQ-023 stop SHALL have priority over start in the same cycle.
REQ-024 start held high SHALL be level-sensitive: after done, if start is still high in IDLE, playback SHALL restart.

Reset
REQ-025 Asserting rst SHALL immediately force IDLE with bz1=0, busy=0, done=0, note_idx=0 and all counters 0, including when asserted mid-note.
REQ-026 Playback after rst deasserts SHALL begin only on a new start.

Configuration
REQ-027 Macro MELODY_LOOP_EN: when defined, the end of GAP with note_idx=7 SHALL wrap to note_idx=0 via LOAD, and done SHALL never assert; playback ends only on stop or rst.
REQ-028 Without MELODY_LOOP_EN, the sequence SHALL play once, as in REQ-021.

Verification (CLK_HZ=20000, DUR_MS=4, GAP_MS=1; tick=20 cycles, note 0 half-period=19)
REQ-029 Pulse start for 1 cycle -> busy=1 the next cycle, LOAD for 1 cycle, then bz1 toggles every 19 cycles for 80 cycles, then 0 for 20 cycles, then note_idx=1.
REQ-030 Single start, no stop -> 8 notes in order 0..7, done pulses exactly once 1 cycle wide, then busy=0 and note_idx=0.
REQ-031 stop asserted 30 cycles into note 2 -> next cycle state IDLE, bz1=0, busy=0, and done never pulses.
REQ-032 start and stop high in the same IDLE cycle -> stays IDLE; start pulse while busy -> no effect on note_idx or timing.
REQ-033 rst asserted asynchronously mid-PLAY with bz1=1 -> bz1=0 and busy=0 without waiting for a clock edge.
REQ-034 With MELODY_LOOP_EN, play past note 7 -> note_idx wraps to 0 with no done pulse; stop then returns to IDLE.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays an 8-note C-major scale as a square wave on bz1.
// Define MELODY_LOOP_EN to repeat the scale until stop or rst instead of playing it once.
module melody_sequencer #(
  parameter int CLK_HZ = 50000000,
  parameter int DUR_MS = 200,
  parameter int GAP_MS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic       bz1,
  output logic       busy,
  output logic       done,
  output logic [2:0] note_idx
);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  localparam int FREQ [8] = '{523, 587, 659, 698, 784, 880, 988, 1047};
  localparam logic [26:0] TICK = 27'(CLK_HZ / 1000);
  localparam logic [7:0] DUR_LAST = 8'(DUR_MS - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_MS > 0 ? GAP_MS - 1 : 0);
  state_t state, state_nxt;
  logic [2:0] idx_nxt;
  logic done_nxt, timing, tick, play_end, gap_end, hold, flip;
  logic [26:0] half_tab [8];
  logic [26:0] half, tone_cnt, pre_cnt;
  logic [7:0] ms_cnt;
  for (genvar g = 0; g < 8; g++) begin : g_half
    assign half_tab[g] = 27'(CLK_HZ / (2 * FREQ[g]));
  end
  assign busy = state != IDLE;
  assign timing = state == PLAY || state == GAP;
  assign tick = timing && pre_cnt == TICK - 27'd1;
  assign play_end = state == PLAY && tick && ms_cnt == DUR_LAST;
  assign gap_end = state == GAP && (GAP_MS == 0 || (tick && ms_cnt == GAP_LAST));
  // counters only run while staying in PLAY/GAP, so every state entry restarts them
  assign hold = timing && state_nxt == state;
  assign flip = tone_cnt == half - 27'd1;
  always_comb begin
    state_nxt = state;
    idx_nxt = note_idx;
    done_nxt = 1'b0;
    if (stop && busy) begin
      state_nxt = IDLE;
      idx_nxt = 3'd0;
    end else begin
      case (state)
        IDLE: if (start && !stop) begin
          state_nxt = LOAD;
          idx_nxt = 3'd0;
        end
        LOAD: state_nxt = PLAY;
        PLAY: if (play_end) state_nxt = GAP;
        GAP: if (gap_end) begin
          idx_nxt = note_idx + 3'd1;
`ifdef MELODY_LOOP_EN
          state_nxt = LOAD;
`else
          state_nxt = note_idx == 3'd7 ? IDLE : LOAD;
          done_nxt = note_idx == 3'd7;
`endif
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      note_idx <= 3'd0;
      done <= 1'b0;
      bz1 <= 1'b0;
      half <= 27'd0;
      tone_cnt <= 27'd0;
      pre_cnt <= 27'd0;
      ms_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      note_idx <= idx_nxt;
      done <= done_nxt;
      if (state == LOAD) half <= half_tab[note_idx];
      tone_cnt <= (state == PLAY && hold && !flip) ? tone_cnt + 27'd1 : 27'd0;
      bz1 <= state == PLAY && hold && (bz1 ^ flip);
      pre_cnt <= (hold && !tick) ? pre_cnt + 27'd1 : 27'd0;
      ms_cnt <= hold ? ms_cnt + 8'(tick) : 8'd0;
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: checks melody_sequencer against a timeline model of the scale.
module tb_melody_sequencer;
  localparam int CLK_HZ = 20000;
  localparam int DUR_MS = 4;
  localparam int GAP_MS = 1;
  localparam int FREQ [8] = '{523, 587, 659, 698, 784, 880, 988, 1047};
  localparam int TICK = CLK_HZ / 1000;
  localparam int PLAYC = DUR_MS * TICK;
  localparam int GAPC = GAP_MS == 0 ? 1 : GAP_MS * TICK;
  localparam int P = 1 + PLAYC + GAPC;
  localparam int FULL = 8 * P;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic bz1, busy, done;
  logic [2:0] note_idx;
  int compared = 0, mismatched = 0;
  melody_sequencer #(.CLK_HZ(CLK_HZ), .DUR_MS(DUR_MS), .GAP_MS(GAP_MS)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .bz1(bz1), .busy(busy), .done(done), .note_idx(note_idx)
  );
  always #5 clk = ~clk;
  // t counts cycles after the accepted start: per note one LOAD cycle, PLAYC play, GAPC gap
  function automatic void model(input int t, output logic ebz, output logic ebusy,
                                output logic edone, output logic [2:0] eidx);
    int tt, n, r;
    tt = t;
`ifdef MELODY_LOOP_EN
    tt = t % FULL;
`endif
    if (tt >= FULL) begin
      ebz = 1'b0;
      ebusy = 1'b0;
      edone = tt == FULL;
      eidx = 3'd0;
    end else begin
      n = tt / P;
      r = tt % P;
      ebusy = 1'b1;
      edone = 1'b0;
      eidx = 3'(n);
      ebz = (r >= 1 && r <= PLAYC) ? 1'(((r - 1) / (CLK_HZ / (2 * FREQ[n]))) % 2) : 1'b0;
    end
  endfunction
  task automatic cmp(input string tag, input logic [2:0] got, input logic [2:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check(input int t, input string tag);
    logic ebz, ebusy, edone;
    logic [2:0] eidx;
    model(t, ebz, ebusy, edone, eidx);
    cmp($sformatf("%s bz1 t=%0d", tag, t), 3'(bz1), 3'(ebz));
    cmp($sformatf("%s busy t=%0d", tag, t), 3'(busy), 3'(ebusy));
    cmp($sformatf("%s done t=%0d", tag, t), 3'(done), 3'(edone));
    cmp($sformatf("%s note_idx t=%0d", tag, t), note_idx, eidx);
  endtask
  task automatic check_idle(input string tag);
    cmp({tag, " bz1"}, 3'(bz1), 3'd0);
    cmp({tag, " busy"}, 3'(busy), 3'd0);
    cmp({tag, " done"}, 3'(done), 3'd0);
    cmp({tag, " note_idx"}, note_idx, 3'd0);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic kick(input bit hold);
    start = 1'b1;
    step;
    start = hold;
  endtask
  task automatic run(input int t0, input int t1, input string tag, input bit spur, input bit hold);
    for (int t = t0; t <= t1; t++) begin
      check(t, tag);
      if (t < t1) begin
        start = hold || (spur && t < FULL && $urandom_range(15, 0) == 0);
        step;
      end
    end
    start = hold;
  endtask
  initial begin
    repeat (2) step;
    check_idle("reset");
    rst = 1'b0;
    step;
    check_idle("idle");
    kick(1'b0);
    run(0, FULL + 2, "full", 1'b1, 1'b0);
    stop = 1'b1;
    step;
    stop = 1'b0;
    check_idle("full_stop");
    start = 1'b1;
    stop = 1'b1;
    step;
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle("start_stop");
      step;
    end
    for (int k = 0; k < 4; k++) begin
      int note, off;
      note = k == 0 ? 2 : int'($urandom_range(7, 0));
      off = k == 0 ? 30 : int'($urandom_range(P - 1, 0));
      kick(1'b0);
      run(0, note * P + off, "pre_stop", 1'b1, 1'b0);
      stop = 1'b1;
      start = k[0];
      step;
      stop = 1'b0;
      start = 1'b0;
      check_idle("after_stop");
      step;
      check_idle("after_stop2");
    end
    kick(1'b1);
    run(0, FULL, "held", 1'b0, 1'b1);
    step;
    cmp("held restart busy", 3'(busy), 3'd1);
    cmp("held restart note_idx", note_idx, 3'd0);
    cmp("held restart done", 3'(done), 3'd0);
    start = 1'b0;
    stop = 1'b1;
    step;
    stop = 1'b0;
    check_idle("held_stop");
    kick(1'b0);
    run(0, 20, "pre_rst", 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 check_idle("async_rst");
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      check_idle("post_rst");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
